// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver fed by the RGB converter ROM.
// Optional gamma shaping at capture: define RGB_PWM_GAMMA_EN.
module rgb_pwm_driver #(
   parameter int PRESCALE = 4,
   parameter int CW       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [23:0] rgb,
   output logic        led_r,
   output logic        led_g,
   output logic        led_b,
   output logic        period_start,
   output logic        pending
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] CNT_MAX = {{(CW-1){1'b1}}, 1'b0};

   logic [PW-1:0] pre_cnt;
   logic [CW-1:0] pwm_cnt;
   logic          en_d;
   logic [23:0]   pend_duty;
   logic [23:0]   act_duty;
   logic [23:0]   cap_duty;
   logic          tick;
   logic          boundary;

   function automatic logic [7:0] shape(input logic [7:0] c);
`ifdef RGB_PWM_GAMMA_EN
      logic [15:0] sq;
      sq = 16'(c) * 16'(c) + 16'(c);
      return sq[15:8];
`else
      return c;
`endif
   endfunction

   assign cap_duty = {shape(rgb[23:16]),
                      shape(rgb[15:8]),
                      shape(rgb[7:0])};

   assign tick     = (pre_cnt == PRE_MAX);
   assign boundary = tick && (pwm_cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         if (tick)
            pwm_cnt <= boundary ? '0 : pwm_cnt + 1'b1;
      end
   end

   // A capture landing on the boundary bypasses the pending stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_d      <= 1'b0;
         pend_duty <= '0;
         act_duty  <= '0;
         pending   <= 1'b0;
      end else begin
         en_d <= enable;
         if (en_d)
            pend_duty <= cap_duty;
         if (boundary) begin
            pending <= 1'b0;
            if (en_d)
               act_duty <= cap_duty;
            else if (pending)
               act_duty <= pend_duty;
         end else if (en_d) begin
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_r        <= 1'b0;
         led_g        <= 1'b0;
         led_b        <= 1'b0;
         period_start <= 1'b0;
      end else begin
         led_r        <= (pwm_cnt < act_duty[23:16]);
         led_g        <= (pwm_cnt < act_duty[15:8]);
         led_b        <= (pwm_cnt < act_duty[7:0]);
         period_start <= boundary;
      end
   end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Randomised bench for rgb_pwm_driver with a period-level model.
// Model duty follows the last capture before each boundary.
module tb_rgb_pwm_driver;

   localparam int P   = 2;
   localparam int PER = 255 * P;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [23:0] rgb;
   logic        led_r, led_g, led_b;
   logic        period_start, pending;

   int n_cmp = 0;
   int n_bad = 0;

   int          k;
   logic        en_prev;
   logic        m_new;
   logic [23:0] m_last;
   logic [23:0] cur;
   logic [23:0] win;
   int          acc_r, acc_g, acc_b;

   rgb_pwm_driver #(.PRESCALE(P), .CW(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .rgb          (rgb),
      .led_r        (led_r),
      .led_g        (led_g),
      .led_b        (led_b),
      .period_start (period_start),
      .pending      (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s k=%0d got=%0d exp=%0d", tag, k, got, exp);
      end
   endtask

   function automatic logic [23:0] gam(input logic [23:0] c);
      logic [23:0] r;
      r = c;
`ifdef RGB_PWM_GAMMA_EN
      for (int i = 0; i < 3; i++) begin
         int v;
         v = int'(c[8*i +: 8]);
         r[8*i +: 8] = 8'((v * v + v) / 256);
      end
`endif
      return r;
   endfunction

   task automatic model_reset();
      k = 0;
      en_prev = 1'b0;
      m_new = 1'b0;
      m_last = '0;
      cur = '0;
      win = '0;
      acc_r = 0;
      acc_g = 0;
      acc_b = 0;
   endtask

   task automatic step(input logic en, input logic [23:0] c);
      logic exp_ps;
      @(negedge clk);
      exp_ps = (k > 0) && (k % PER == 0);
      check("period_start", int'(period_start), int'(exp_ps));
      check("pending", int'(pending), int'(m_new));
      acc_r += int'(led_r);
      acc_g += int'(led_g);
      acc_b += int'(led_b);
      if (exp_ps) begin
         check("cnt_r", acc_r, int'(win[23:16]) * P);
         check("cnt_g", acc_g, int'(win[15:8]) * P);
         check("cnt_b", acc_b, int'(win[7:0]) * P);
         acc_r = 0;
         acc_g = 0;
         acc_b = 0;
         win = cur;
      end
      enable = en;
      rgb = c;
      if (en_prev) begin
         m_last = gam(c);
         m_new = 1'b1;
      end
      if ((k % PER == PER - 1) && m_new) begin
         cur = m_last;
         m_new = 1'b0;
      end
      en_prev = en;
      k++;
   endtask

   task automatic run_per(input int o1, input logic [23:0] c1,
                          input int o2, input logic [23:0] c2);
      for (int i = 0; i < PER; i++) begin
         int p;
         logic [23:0] v;
         p = k % PER;
         v = 24'($urandom);
         if (o1 >= 0 && p == o1 + 1) v = c1;
         if (o2 >= 0 && p == o2 + 1) v = c2;
         step((p == o1) || (p == o2), v);
      end
   endtask

   task automatic run_rand(input int mode);
      for (int i = 0; i < PER; i++) begin
         logic e;
         e = (mode == 1) ? 1'b1 : ($urandom_range(0, 63) == 0);
         step(e, 24'($urandom));
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      enable = 1'b0;
      #1;
      check("rst_led_r", int'(led_r), 0);
      check("rst_led_g", int'(led_g), 0);
      check("rst_led_b", int'(led_b), 0);
      check("rst_ps", int'(period_start), 0);
      check("rst_pend", int'(pending), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n = 1'b0;
      enable = 1'b0;
      rgb = '0;
      model_reset();
      do_reset();
      run_per(10, 24'hFF8000, -1, 24'h0);
      run_per(5, 24'h010000, -1, 24'h0);
      run_per(3, 24'h100000, 100, 24'h200000);
      run_per(PER - 2, 24'h00FF00, -1, 24'h0);
      run_per(7, 24'h80FF00, -1, 24'h0);
      run_per(-1, 24'h0, -1, 24'h0);
      run_rand(1);
      for (int j = 0; j < 5; j++)
         run_rand(0);
      for (int j = 0; j < 137; j++)
         step(1'b0, 24'($urandom));
      do_reset();
      run_per(-1, 24'h0, -1, 24'h0);
      run_per(20, 24'h3C7FC3, -1, 24'h0);
      run_rand(0);
      run_per(-1, 24'h0, -1, 24'h0);
      step(1'b0, 24'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
